l_shl_arbiter: RTL and testbench

- Shares the single multi-cycle L_shl (32-bit saturating left shift) unit among N sequential sub-blocks of the Qua_Lsp path, e.g. Get_wegt and Lsp_expand-style loops.
- Captures each requester's one-cycle ready pulse and its operands, then grants requests round-robin.
- Drives the unit's ready/done handshake and returns a one-cycle done pulse plus the result to the owning requester.
- Sits between the requester FSMs and the L_shl instance in the top-level datapath.

---
 rtl/l_shl_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_l_shl_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l_shl_arbiter.sv
// l_shl_arbiter
//   Shares one multi-cycle L_shl (32-bit saturating left shift) unit among N
//   requesters. Each requester's one-cycle ready pulse and operands are
//   captured into a pending slot. Pending slots are granted round-robin, the
//   unit is driven through its ready/done handshake, and the result is
//   returned to the owner with a one-cycle done pulse.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   reqReady[N]       : per-requester request pulse
//   reqVar1[32*N]     : requester i operand in bits [32i+31:32i]
//   reqNumShift[16*N] : requester i shift count in bits [16i+15:16i]
//   reqDone[N]        : one-cycle completion pulse to the owning requester
//   reqResult[32]     : result, held until the next capture
//   L_shlOutVar1, L_shlNumShiftOut, L_shlReady : operands / start to the unit
//   L_shlIn, L_shlDone                         : result / completion from the unit
//   grantIdx          : current or last granted requester (debug)
//   busy              : arbiter is not idle
//   overrun           : sticky, a requester pulsed again while still pending
module l_shl_arbiter #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      reqReady,
    input  logic [32*N-1:0]   reqVar1,
    input  logic [16*N-1:0]   reqNumShift,
    output logic [N-1:0]      reqDone,
    output logic [31:0]       reqResult,
    output logic [31:0]       L_shlOutVar1,
    output logic [15:0]       L_shlNumShiftOut,
    output logic              L_shlReady,
    input  logic [31:0]       L_shlIn,
    input  logic              L_shlDone,
    output logic [IDXW-1:0]   grantIdx,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [N-1:0]           pend_q, pend_d;
    logic [N-1:0][31:0]     opa_q, opa_d;
    logic [N-1:0][15:0]     ops_q, ops_d;
    logic [IDXW-1:0]        ptr_q, ptr_d;
    logic [N-1:0]           req_done_q, req_done_d;
    logic [31:0]            req_result_q, req_result_d;
    logic [31:0]            out_var1_q, out_var1_d;
    logic [15:0]            out_shift_q, out_shift_d;
    logic                   l_shl_ready_q, l_shl_ready_d;
    logic [IDXW-1:0]        grant_idx_q, grant_idx_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    logic                   found_s;
    logic [IDXW-1:0]        grant_s;
    logic [IDXW-1:0]        cand_s;
    logic                   grant_fire_s;

    // Round-robin search: first pending slot at or after ptr, wrapping modulo N.
    always_comb begin
        found_s = 1'b0;
        grant_s = '0;
        cand_s  = '0;
        for (int k = 0; k < N; k++) begin
            cand_s = IDXW'((int'(ptr_q) + k) % N);
            if (!found_s && pend_q[cand_s]) begin
                found_s = 1'b1;
                grant_s = cand_s;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    assign grant_fire_s = (state_q == ST_IDLE) && found_s;

    // Request capture. A new pulse on a slot being granted this cycle re-arms
    // it with the new operands; a pulse on a slot still waiting is dropped and
    // flagged as overrun.
    always_comb begin
        pend_d    = pend_q;
        opa_d     = opa_q;
        ops_d     = ops_q;
        overrun_d = overrun_q;
        for (int i = 0; i < N; i++) begin
            if (reqReady[i]) begin
                if (pend_q[i] && !(grant_fire_s && (grant_s == IDXW'(i)))) begin
                    overrun_d = 1'b1;
                end else begin
                    pend_d[i] = 1'b1;
                    opa_d[i]  = reqVar1[32*i +: 32];
                    ops_d[i]  = reqNumShift[16*i +: 16];
                end
            end else if (grant_fire_s && (grant_s == IDXW'(i))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Handshake FSM next-state and output values. Outputs are computed one
    // cycle ahead so that every port comes straight from a flop.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        req_done_d    = '0;
        req_result_d  = req_result_q;
        out_var1_d    = out_var1_q;
        out_shift_d   = out_shift_q;
        l_shl_ready_d = 1'b0;
        grant_idx_d   = grant_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_fire_s) begin
                    state_d       = ST_ISSUE;
                    out_var1_d    = opa_q[grant_s];
                    out_shift_d   = ops_q[grant_s];
                    grant_idx_d   = grant_s;
                    l_shl_ready_d = 1'b1;
                    ptr_d         = (grant_s == IDXW'(N - 1)) ? '0 : grant_s + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (L_shlDone) begin
                    req_result_d = L_shlIn;
                    state_d      = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                req_done_d[grant_idx_q] = 1'b1;
                state_d                 = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            pend_q        <= '0;
            opa_q         <= '0;
            ops_q         <= '0;
            ptr_q         <= '0;
            req_done_q    <= '0;
            req_result_q  <= 32'd0;
            out_var1_q    <= 32'd0;
            out_shift_q   <= 16'd0;
            l_shl_ready_q <= 1'b0;
            grant_idx_q   <= '0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_q        <= pend_d;
            opa_q         <= opa_d;
            ops_q         <= ops_d;
            ptr_q         <= ptr_d;
            req_done_q    <= req_done_d;
            req_result_q  <= req_result_d;
            out_var1_q    <= out_var1_d;
            out_shift_q   <= out_shift_d;
            l_shl_ready_q <= l_shl_ready_d;
            grant_idx_q   <= grant_idx_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
        end
    end

    assign reqDone          = req_done_q;
    assign reqResult        = req_result_q;
    assign L_shlOutVar1     = out_var1_q;
    assign L_shlNumShiftOut = out_shift_q;
    assign L_shlReady       = l_shl_ready_q;
    assign grantIdx         = grant_idx_q;
    assign busy             = busy_q;
    assign overrun          = overrun_q;

endmodule

// File: tb/tb_l_shl_arbiter.sv
// Directed testbench for l_shl_arbiter (N=4). The L_shl unit is played by
// the bench: it raises L_shlDone with a hand-chosen result at fixed points.
module tb_l_shl_arbiter;

    localparam int N    = 4;
    localparam int IDXW = 2;

    logic              clk;
    logic              reset;
    logic [N-1:0]      reqReady;
    logic [32*N-1:0]   reqVar1;
    logic [16*N-1:0]   reqNumShift;
    logic [N-1:0]      reqDone;
    logic [31:0]       reqResult;
    logic [31:0]       L_shlOutVar1;
    logic [15:0]       L_shlNumShiftOut;
    logic              L_shlReady;
    logic [31:0]       L_shlIn;
    logic              L_shlDone;
    logic [IDXW-1:0]   grantIdx;
    logic              busy;
    logic              overrun;

    int vectors;
    int miscompares;

    l_shl_arbiter #(.N(N), .IDXW(IDXW)) dut (
        .clk              (clk),
        .reset            (reset),
        .reqReady         (reqReady),
        .reqVar1          (reqVar1),
        .reqNumShift      (reqNumShift),
        .reqDone          (reqDone),
        .reqResult        (reqResult),
        .L_shlOutVar1     (L_shlOutVar1),
        .L_shlNumShiftOut (L_shlNumShiftOut),
        .L_shlReady       (L_shlReady),
        .L_shlIn          (L_shlIn),
        .L_shlDone        (L_shlDone),
        .grantIdx         (grantIdx),
        .busy             (busy),
        .overrun          (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] v, input logic [15:0] s);
        reqReady[i]             = 1'b1;
        reqVar1[32*i +: 32]     = v;
        reqNumShift[16*i +: 16] = s;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Bounded wait for the start pulse to the unit.
    task automatic wait_ready(input string tag);
        for (int k = 0; k < 20; k++) begin
            if (L_shlReady === 1'b1) break;
            tick();
        end
        chk(tag, 32'(L_shlReady), 32'd1);
    endtask

    // Unit completes now; reqDone must follow two cycles after the done cycle.
    task automatic finish_op(input string tag, input int idx, input logic [31:0] res);
        L_shlIn   = res;
        L_shlDone = 1'b1;
        tick();
        L_shlDone = 1'b0;
        L_shlIn   = 32'hBAD0_BAD0;
        chk({tag, "_done_early"}, 32'(reqDone), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(reqDone), 32'd1 << idx);
        chk({tag, "_result"}, reqResult, res);
    endtask

    task automatic serve(input string tag, input logic [31:0] v, input logic [15:0] s,
                         input int idx, input logic [31:0] res);
        wait_ready({tag, "_ready"});
        chk({tag, "_var1"}, L_shlOutVar1, v);
        chk({tag, "_shift"}, 32'(L_shlNumShiftOut), 32'(s));
        chk({tag, "_gidx"}, 32'(grantIdx), 32'(idx));
        tick();
        chk({tag, "_ready_pulse"}, 32'(L_shlReady), 32'd0);
        tick();
        finish_op(tag, idx, res);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        reqReady    = '0;
        reqVar1     = '0;
        reqNumShift = '0;
        L_shlIn     = 32'd0;
        L_shlDone   = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_reqDone", 32'(reqDone), 32'd0);
        chk("rst_reqResult", reqResult, 32'd0);
        chk("rst_var1", L_shlOutVar1, 32'd0);
        chk("rst_shift", 32'(L_shlNumShiftOut), 32'd0);
        chk("rst_ready", 32'(L_shlReady), 32'd0);
        chk("rst_gidx", 32'(grantIdx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);

        // Single request with exact latency
        set_req(0, 32'h0000_1234, 16'd2);
        tick();
        reqReady = '0;
        chk("t1_ready_t1", 32'(L_shlReady), 32'd0);
        chk("t1_busy_t1", 32'(busy), 32'd0);
        tick();
        chk("t1_ready_t2", 32'(L_shlReady), 32'd1);
        chk("t1_var1", L_shlOutVar1, 32'h0000_1234);
        chk("t1_shift", 32'(L_shlNumShiftOut), 32'd2);
        chk("t1_gidx", 32'(grantIdx), 32'd0);
        chk("t1_busy_t2", 32'(busy), 32'd1);
        tick();
        chk("t1_ready_t3", 32'(L_shlReady), 32'd0);
        tick();
        tick();
        finish_op("t1", 0, 32'h0000_48D0);
        chk("t1_busy_resp", 32'(busy), 32'd0);
        tick();
        chk("t1_done_width", 32'(reqDone), 32'd0);
        chk("t1_result_hold", reqResult, 32'h0000_48D0);
        chk("t1_var1_hold", L_shlOutVar1, 32'h0000_1234);

        // Simultaneous requests from a fresh pointer: order 0,1,3
        do_reset();
        set_req(0, 32'h0000_0011, 16'd1);
        set_req(1, 32'h0000_0022, 16'd2);
        set_req(3, 32'h0000_0044, 16'd4);
        tick();
        reqReady = '0;
        serve("t2_g0", 32'h0000_0011, 16'd1, 0, 32'h0000_0022);
        serve("t2_g1", 32'h0000_0022, 16'd2, 1, 32'h0000_0088);
        serve("t2_g3", 32'h0000_0044, 16'd4, 3, 32'h0000_0440);
        // Pointer wrapped to 0: requester 0 beats requester 3
        set_req(0, 32'h0000_00A0, 16'd0);
        set_req(3, 32'h0000_00B3, 16'd0);
        tick();
        reqReady = '0;
        serve("t2_wrap0", 32'h0000_00A0, 16'd0, 0, 32'h0000_00A0);
        serve("t2_wrap3", 32'h0000_00B3, 16'd0, 3, 32'h0000_00B3);

        // Fairness: 0 and 2 keep re-requesting, grants alternate
        set_req(0, 32'h0000_00C0, 16'd1);
        set_req(2, 32'h0000_00C2, 16'd2);
        tick();
        reqReady = '0;
        serve("t3_a0", 32'h0000_00C0, 16'd1, 0, 32'h0000_0180);
        set_req(0, 32'h0000_00D0, 16'd3);
        tick();
        reqReady = '0;
        serve("t3_a2", 32'h0000_00C2, 16'd2, 2, 32'h0000_0308);
        set_req(2, 32'h0000_00D2, 16'd4);
        tick();
        reqReady = '0;
        serve("t3_b0", 32'h0000_00D0, 16'd3, 0, 32'h0000_0680);
        serve("t3_b2", 32'h0000_00D2, 16'd4, 2, 32'h0000_0D20);

        // Overrun: requester 1 pulses twice while requester 0 holds the unit
        chk("t4_overrun_pre", 32'(overrun), 32'd0);
        set_req(0, 32'h0000_0100, 16'd3);
        tick();
        reqReady = '0;
        wait_ready("t4_ready0");
        chk("t4_var1_0", L_shlOutVar1, 32'h0000_0100);
        set_req(1, 32'd5, 16'd1);
        tick();
        reqReady = '0;
        set_req(1, 32'd9, 16'd7);
        tick();
        reqReady = '0;
        chk("t4_overrun", 32'(overrun), 32'd1);
        finish_op("t4_r0", 0, 32'h0000_0800);
        serve("t4_r1", 32'd5, 16'd1, 1, 32'h0000_000A);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t4_no_second_grant", 32'(L_shlReady), 32'd0);
        end
        chk("t4_idle", 32'(busy), 32'd0);
        chk("t4_overrun_sticky", 32'(overrun), 32'd1);

        // Spurious done in IDLE
        L_shlIn   = 32'h5A5A_5A5A;
        L_shlDone = 1'b1;
        tick();
        L_shlDone = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t5_spur_done", 32'(reqDone), 32'd0);
            chk("t5_spur_busy", 32'(busy), 32'd0);
            tick();
        end
        chk("t5_result_hold", reqResult, 32'h0000_000A);

        // Unit stall: 50 cycles in WAIT with no done
        set_req(2, 32'hDEAD_0000, 16'd16);
        tick();
        reqReady = '0;
        wait_ready("t6_ready");
        tick();
        for (int k = 0; k < 50; k++) begin
            chk("t6_busy", 32'(busy), 32'd1);
            chk("t6_var1", L_shlOutVar1, 32'hDEAD_0000);
            chk("t6_shift", 32'(L_shlNumShiftOut), 32'd16);
            chk("t6_done", 32'(reqDone), 32'd0);
            tick();
        end
        finish_op("t6", 2, 32'h8000_0000);

        // Reset while in WAIT with another requester pending
        set_req(3, 32'h0000_0333, 16'd5);
        tick();
        reqReady = '0;
        wait_ready("t7_ready");
        tick();
        set_req(1, 32'h0000_0111, 16'd1);
        tick();
        reqReady = '0;
        do_reset();
        chk("t7_reqDone", 32'(reqDone), 32'd0);
        chk("t7_reqResult", reqResult, 32'd0);
        chk("t7_var1", L_shlOutVar1, 32'd0);
        chk("t7_shift", 32'(L_shlNumShiftOut), 32'd0);
        chk("t7_ready", 32'(L_shlReady), 32'd0);
        chk("t7_gidx", 32'(grantIdx), 32'd0);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_overrun", 32'(overrun), 32'd0);
        L_shlIn   = 32'h0000_0999;
        L_shlDone = 1'b1;
        tick();
        L_shlDone = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t7_late_done", 32'(reqDone), 32'd0);
            chk("t7_late_busy", 32'(busy), 32'd0);
            chk("t7_pend_clear", 32'(L_shlReady), 32'd0);
            tick();
        end

        // Re-pulse on the grant cycle re-arms the slot without overrun
        set_req(0, 32'h0000_AAAA, 16'd1);
        tick();
        set_req(0, 32'h0000_BBBB, 16'd2);
        tick();
        reqReady = '0;
        chk("t8_no_overrun", 32'(overrun), 32'd0);
        serve("t8_first", 32'h0000_AAAA, 16'd1, 0, 32'h0001_5554);
        serve("t8_second", 32'h0000_BBBB, 16'd2, 0, 32'h0002_EEEC);
        chk("t8_overrun_end", 32'(overrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
